// File: rtl/arm7tdmi_imem_responder.sv
`default_nettype none
// ==========================================================================
// Module   : arm7tdmi_imem_responder
// Brief    : Single-port word memory answering ARM7TDMI-style byte/half/word
//            accesses with abort detection; optional wait states are built
//            only when macro IMEM_WAITSTATE_EN is defined.
// Revision : 1.0 - initial release
// ==========================================================================
module arm7tdmi_imem_responder #(
    parameter int unsigned DEPTH_WORDS = 4096,
    parameter logic [31:0] BASE_ADDR   = 32'h0000_0000,
    parameter int unsigned WAIT_CYCLES = 1
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic [31:0] imem_vaddr,
    input  logic        imem_req,
    input  logic        imem_write,
    input  logic [1:0]  imem_size,
    input  logic [31:0] imem_wdata,
    output logic [31:0] imem_rdata,
    output logic        imem_ready,
    output logic        imem_abort,
    output logic        busy
);
    localparam int unsigned c_AW = (DEPTH_WORDS > 1) ? $clog2(DEPTH_WORDS) : 1;

    localparam logic [1:0] c_IDLE = 2'd0;
`ifdef IMEM_WAITSTATE_EN
    localparam logic [1:0] c_WAIT = 2'd1;
    localparam logic [3:0] c_WAIT_LAST = (WAIT_CYCLES == 0) ? 4'd0 : 4'(WAIT_CYCLES - 1);
`endif
    localparam logic [1:0] c_RESP = 2'd2;

    generate
        if (WAIT_CYCLES > 15) begin : g_chk_wait
            $error("WAIT_CYCLES must be in 0..15");
        end
        if ((64'(BASE_ADDR) % (64'(DEPTH_WORDS) * 64'd4)) != 64'd0) begin : g_chk_base
            $error("BASE_ADDR must be aligned to DEPTH_WORDS*4");
        end
    endgenerate

    logic [31:0]     r_mem [DEPTH_WORDS];
    logic [1:0]      r_state;
    logic [31:0]     r_rdata;
    logic            r_ready;
    logic            r_abort;

    logic [31:0]     w_acc_vaddr;
    logic            w_acc_write;
    logic [1:0]      w_acc_size;
    logic [31:0]     w_acc_wdata;
    logic            w_enter_resp;

`ifdef IMEM_WAITSTATE_EN
    logic [31:0]     r_vaddr;
    logic            r_write;
    logic [1:0]      r_size;
    logic [31:0]     r_wdata;
    logic [3:0]      r_cnt;

    // With zero wait states the access commits on the accepting edge, so the
    // live request fields are used; otherwise the captured copy is.
    assign w_acc_vaddr  = (r_state == c_IDLE) ? imem_vaddr : r_vaddr;
    assign w_acc_write  = (r_state == c_IDLE) ? imem_write : r_write;
    assign w_acc_size   = (r_state == c_IDLE) ? imem_size  : r_size;
    assign w_acc_wdata  = (r_state == c_IDLE) ? imem_wdata : r_wdata;
    assign w_enter_resp = ((r_state == c_IDLE) && imem_req && (WAIT_CYCLES == 0)) ||
                          ((r_state == c_WAIT) && (r_cnt == c_WAIT_LAST));
`else
    assign w_acc_vaddr  = imem_vaddr;
    assign w_acc_write  = imem_write;
    assign w_acc_size   = imem_size;
    assign w_acc_wdata  = imem_wdata;
    assign w_enter_resp = (r_state == c_IDLE) && imem_req;
`endif

    logic [31:0]     w_off;
    logic            w_in_range;
    logic            w_bad_align;
    logic            w_abort;
    logic [c_AW-1:0] w_idx;
    logic [3:0]      w_be;
    logic [31:0]     w_wlane;
    logic            w_commit;

    // BASE_ADDR is aligned, so the low offset bits equal the address lane bits.
    assign w_off       = w_acc_vaddr - BASE_ADDR;
    assign w_in_range  = ({1'b0, w_off[31:2]} < 31'(DEPTH_WORDS));
    assign w_bad_align = (w_acc_size == 2'b11) ||
                         ((w_acc_size == 2'b01) && w_off[0]) ||
                         ((w_acc_size == 2'b10) && (w_off[1:0] != 2'b00));
    assign w_abort     = !w_in_range || w_bad_align;
    assign w_idx       = w_off[c_AW+1:2];
    assign w_commit    = w_enter_resp && w_acc_write && !w_abort;

    always_comb begin
        w_be    = 4'b0000;
        w_wlane = w_acc_wdata;
        case (w_acc_size)
            2'b00: begin
                w_be    = 4'b0001 << w_off[1:0];
                w_wlane = {4{w_acc_wdata[7:0]}};
            end
            2'b01: begin
                w_be    = w_off[1] ? 4'b1100 : 4'b0011;
                w_wlane = {2{w_acc_wdata[15:0]}};
            end
            2'b10:   w_be = 4'b1111;
            default: w_be = 4'b0000;
        endcase
    end

    // Storage is never reset; a write is suppressed while reset is asserted.
    always_ff @(posedge clk) begin
        if (rst_n && w_commit) begin
            for (int b = 0; b < 4; b++) begin
                if (w_be[b]) begin
                    r_mem[w_idx][8*b +: 8] <= w_wlane[8*b +: 8];
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state <= c_IDLE;
            r_ready <= 1'b0;
            r_abort <= 1'b0;
            r_rdata <= 32'h0;
`ifdef IMEM_WAITSTATE_EN
            r_cnt   <= 4'd0;
`endif
        end else begin
            r_ready <= w_enter_resp;
            r_abort <= w_enter_resp && w_abort;
            if (w_enter_resp) begin
                r_rdata <= (w_abort || w_acc_write) ? 32'h0 : r_mem[w_idx];
            end
            case (r_state)
                c_IDLE: begin
                    if (imem_req) begin
`ifdef IMEM_WAITSTATE_EN
                        r_vaddr <= imem_vaddr;
                        r_write <= imem_write;
                        r_size  <= imem_size;
                        r_wdata <= imem_wdata;
                        r_cnt   <= 4'd0;
                        r_state <= (WAIT_CYCLES == 0) ? c_RESP : c_WAIT;
`else
                        r_state <= c_RESP;
`endif
                    end
                end
`ifdef IMEM_WAITSTATE_EN
                c_WAIT: begin
                    r_cnt <= r_cnt + 4'd1;
                    if (w_enter_resp) begin
                        r_state <= c_RESP;
                    end
                end
`endif
                c_RESP:  r_state <= c_IDLE;
                default: r_state <= c_IDLE;
            endcase
        end
    end

    assign imem_rdata = r_rdata;
    assign imem_ready = r_ready;
    assign imem_abort = r_abort;
    assign busy       = (r_state != c_IDLE);

endmodule
`default_nettype wire

// File: doc/arm7tdmi_imem_responder.md
ARM7TDMI_IMEM_RESPONDER -- requirements
Module: arm7tdmi_imem_responder

Interface
REQ-001 SHALL have parameter DEPTH_WORDS, default 4096, number of 32-bit words of backing storage.
REQ-002 SHALL have parameter BASE_ADDR, default 32'h0000_0000, byte address of word 0; must be aligned to DEPTH_WORDS*4.
REQ-003 SHALL have parameter WAIT_CYCLES, default 1, wait states inserted before each response (0..15).
REQ-004 SHALL have port clk  input  1  sole clock; all state updates on the rising edge.
REQ-005 SHALL have port rst_n  input  1  reset, synchronous, active-low.
REQ-006 SHALL have port imem_vaddr  input  32  byte address of the access.
REQ-007 SHALL have port imem_req  input  1  access request; initiator holds it and all request fields stable until imem_ready.
REQ-008 SHALL have port imem_write  input  1  1 = write, 0 = read.
REQ-009 SHALL have port imem_size  input  2  00 byte, 01 halfword, 10 word, 11 illegal.
REQ-010 SHALL have port imem_wdata  input  32  write data, little-endian lanes.
REQ-011 SHALL have port imem_rdata  output  32  read data, registered.
REQ-012 SHALL have port imem_ready  output  1  one-cycle completion pulse, registered.
REQ-013 SHALL have port imem_abort  output  1  error flag, valid only with imem_ready.
REQ-014 SHALL have port busy  output  1  high in any state other than IDLE.

Function
REQ-015 SHALL implement FSM states IDLE, WAIT, RESP.
REQ-016 In IDLE with imem_req=1 at an edge, SHALL capture vaddr/write/size/wdata and go to WAIT if WAIT_CYCLES>0, else to RESP.
REQ-017 In WAIT, SHALL count captured wait states; after exactly WAIT_CYCLES cycles in WAIT, SHALL go to RESP.
REQ-018 In RESP, imem_ready SHALL be 1 for exactly one cycle, then the FSM returns to IDLE; imem_req is ignored during RESP.
REQ-019 Latency: imem_ready high in the cycle starting WAIT_CYCLES+1 edges after the accepting edge; minimum request spacing WAIT_CYCLES+2 cycles.
REQ-020 Abort SHALL be raised (imem_abort=1 with imem_ready=1, imem_rdata=0, no storage update) when: address outside [BASE_ADDR, BASE_ADDR+DEPTH_WORDS*4); size=11; halfword with vaddr[0]=1; word with vaddr[1:0]!=0.
REQ-021 Non-aborted read SHALL return the full aligned word at index (vaddr-BASE_ADDR)>>2 for every size; lane extraction is the initiator's job.
REQ-022 Non-aborted byte write SHALL store wdata[7:0] into lane vaddr[1:0] only; halfword write SHALL store wdata[15:0] into lane vaddr[1] only; word write SHALL store all 32 bits.
REQ-023 Write SHALL commit on the edge entering RESP; write responses SHALL return imem_rdata=0.
REQ-024 Outside RESP, imem_ready and imem_abort SHALL be 0 and imem_rdata SHALL hold its last value.
REQ-025 Storage SHALL be preloadable from the bench by hierarchical access; contents are not initialised by the block.

Reset
REQ-026 rst_n=0 at an edge SHALL force IDLE, wait counter 0, imem_ready=0, imem_abort=0, imem_rdata=0, busy=0.
REQ-027 Reset during WAIT or RESP SHALL discard the pending access without writing storage and without a ready pulse.
REQ-028 Storage contents SHALL NOT be affected by reset.

Configuration
REQ-029 Macro IMEM_WAITSTATE_EN: when defined, WAIT state and counter are compiled in and WAIT_CYCLES applies.
REQ-030 Without IMEM_WAITSTATE_EN, WAIT state and counter SHALL be absent, WAIT_CYCLES ignored, and every access completes with WAIT_CYCLES=0 timing (ready one cycle after acceptance).

Verification
REQ-031 Preload word0=E3A00001, word1=E3A01002, WAIT_CYCLES=1; read 0x0 then 0x4 -> ready 2 cycles after each accept, rdata E3A00001 then E3A01002, abort=0.
REQ-032 Halfword read 0x42 with word16=21012001 -> rdata 21012001, abort=0; halfword read 0x41 -> ready with abort=1, rdata 0.
REQ-033 Word16=21012001; byte write 0xAA to 0x41, halfword write 0xBEEF to 0x42, then read 0x40 -> rdata BEEFAA01.
REQ-034 Word read at BASE_ADDR+DEPTH_WORDS*4 and size=11 read at 0x0 -> abort=1 each; follow-up read 0x0 -> correct data, abort=0.
REQ-035 Assert rst_n=0 one cycle after accepting word write 0xDEADBEEF to 0x8 (WAIT_CYCLES=3) -> no ready pulse, outputs 0; read 0x8 returns prior contents.
REQ-036 Build without IMEM_WAITSTATE_EN, WAIT_CYCLES=5 -> read 0x0 completes one cycle after acceptance, rdata E3A00001.
